issue_queue: RTL
================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, which sets the FIFO entry count (power of two, at least 2).
REQ-002 SHALL have parameter NUM_RS, default 4, the number of reservation stations; RS ids run 1..NUM_RS.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port ENQ_VALID, input, 1 bit: a decoded task is offered.
REQ-006 SHALL have port ENQ_TASK, input, task_t: the decoded task (rs1, rs2, rd, op fields).
REQ-007 SHALL have port ENQ_READY, output, 1 bit: the queue can accept a task this cycle.
REQ-008 SHALL have port RS_BUSY, input, NUM_RS bits: bit i-1 is the busy flag of RS i.
REQ-009 SHALL have port CDB_VALID, input, 1 bit: a broadcast is on the CDB.
REQ-010 SHALL have port CDB_TAG, input, RS_tag_type: the tag of the producing RS.
REQ-011 SHALL have port FLUSH, input, 1 bit: discard all queued and in-flight state.
REQ-012 SHALL have port DISPATCH_VALID, output, 1 bit: the head task is dispatched this cycle.
REQ-013 SHALL have port DISPATCH_TASK, output, task_t: the head task.
REQ-014 SHALL have port DEST_RES, output, RS_tag_type: the RS id receiving the task.
REQ-015 SHALL have ports T1 and T2, output, RS_tag_type each: producer tags for rs1 and rs2; TAG_NONE (0) means the operand is ready.

Function
REQ-016 SHALL be an in-order FIFO of DEPTH entries with an occupancy counter 0..DEPTH; read and write pointers wrap modulo DEPTH.
REQ-017 SHALL drive ENQ_READY = (count != DEPTH); a dequeue in the same cycle does not free space for that cycle's enqueue.
REQ-018 SHALL write ENQ_TASK on an edge where ENQ_VALID && ENQ_READY; the entry becomes dispatchable no earlier than the next cycle.
REQ-019 SHALL treat RS i as free when !RS_BUSY[i-1] && !alloc[i], where alloc is an internal NUM_RS-bit claim vector.
REQ-020 SHALL assert DISPATCH_VALID combinationally when count != 0, at least one RS is free, and FLUSH is low; DEST_RES is then the lowest-numbered free RS.
REQ-021 SHALL pop the head, set alloc[DEST_RES], and update the map table on an edge where DISPATCH_VALID is high; at most one dispatch per cycle.
REQ-022 SHALL clear alloc[CDB_TAG] on an edge where CDB_VALID is high.
REQ-023 SHALL hold a 32-entry map table (register to RS_tag_type); x0 reads TAG_NONE always and is never written.
REQ-024 SHALL drive T1 = map[rs1] and T2 = map[rs2], each forced to TAG_NONE when CDB_VALID && CDB_TAG equals that entry (same-cycle bypass).
REQ-025 SHALL, on dispatch with rd != 0, write map[rd] <= DEST_RES.
REQ-026 SHALL, on CDB_VALID, clear every map entry equal to CDB_TAG.
REQ-027 SHALL give a same-edge dispatch write to map[rd] priority over a CDB clear of that entry.
REQ-028 SHALL compute T1 and T2 from the map state before a same-cycle dispatch; a task whose rs equals its own rd reads the older producer.
REQ-029 SHALL support simultaneous enqueue and dispatch, leaving the count unchanged.
REQ-030 SHALL, on FLUSH, suppress dispatch that cycle and on the next edge zero the count and pointers, the map table, and alloc; ENQ is ignored that edge.
REQ-031 SHALL ignore a CDB_TAG of TAG_NONE or greater than NUM_RS.

Reset
REQ-032 SHALL, on an edge with RST_N low, zero the count and pointers, set every map entry to TAG_NONE, and clear alloc.
REQ-033 SHALL hold DISPATCH_VALID and ENQ_READY at 0 while RST_N is low; after release ENQ_READY is 1 and DISPATCH_VALID is 0.
REQ-034 SHALL let a reset mid-operation drop all queued tasks with no dispatch on the reset edge.

Structure
REQ-035 SHALL take RS_tag_type, task_t, TAG_NONE and NUM_RS defaults from the shared package cpu_types.
REQ-036 SHALL implement the map table as one sub-module, reg_status_table (2 read ports, 1 write port, broadcast clear, bypass).

Verification
REQ-037 SHALL cover reset then enqueue of add x3,x1,x2 with RS_BUSY=0000: dispatch on the next cycle with DEST_RES=1, T1=T2=0, and map[x3]=1.
REQ-038 SHALL cover a dependent pair, add x3 then sub x4,x3,x1: second task dispatches with DEST_RES=2 and T1=1; then CDB tag 1 clears map[x3].
REQ-039 SHALL cover CDB tag 1 in the same cycle sub x5,x3,x0 dispatches: T1=0 (bypass applied).
REQ-040 SHALL cover a full queue with RS_BUSY=1111: ENQ_READY=0 and DISPATCH_VALID=0; RS_BUSY=1110 gives DEST_RES=1 and ENQ_READY=1 on the next cycle.
REQ-041 SHALL cover dispatch of rd=x7 to RS2 on the same edge as CDB tag 2 clears the old map[x7]=2: map[x7]=2 survives.
REQ-042 SHALL cover FLUSH with 3 queued tasks: no dispatch, then count=0, all map entries 0, and ENQ_READY=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types: shared types for the out-of-order front end.
//   RS_tag_type    : reservation-station tag, 0 (TAG_NONE) means "no producer"
//   task_t         : decoded task (op, rd, rs1, rs2)
//   DEFAULT_NUM_RS : default number of reservation stations
//   lowest_free()  : lowest-numbered free RS as a tag
//   tag_valid()    : tag names a real RS (1..num_rs)
package cpu_types;

   localparam int DEFAULT_NUM_RS = 4;
   localparam int TAG_W          = 3;
   // Widest RS vector a 3-bit tag can address (tags 1..7).
   localparam int MAX_RS         = 7;

   typedef logic [TAG_W-1:0] RS_tag_type;

   localparam RS_tag_type TAG_NONE = 3'd0;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SLL = 4'd5,
      OP_SRL = 4'd6,
      OP_SLT = 4'd7
   } op_e;

   typedef struct packed {
      op_e        op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } task_t;

   // Bit i of free_vec is RS i+1; returns TAG_NONE when nothing is free.
   function automatic RS_tag_type lowest_free(input logic [MAX_RS-1:0] free_vec);
      RS_tag_type res;
      res = TAG_NONE;
      for (int i = MAX_RS - 1; i >= 0; i--) begin
         if (free_vec[i]) begin
            res = RS_tag_type'(i + 1);
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic tag_valid(input RS_tag_type tag, input int num_rs);
      return (tag != TAG_NONE) && (int'(tag) <= num_rs);
   endfunction

endpackage

// File: rtl/issue_queue_reg_status_table.sv
// reg_status_table: register -> producing-RS map for 32 architectural registers.
//   clk, rst_n          : clock, synchronous active-low reset
//   clear               : synchronous wipe of every entry
//   rd_addr1/2, rd_tag1/2 : two read ports; x0 and entries matching a live
//                           broadcast read as TAG_NONE (same-cycle bypass)
//   wr_en, wr_addr, wr_tag: single write port, wins over a broadcast clear
//   bc_valid, bc_tag    : broadcast clear of every entry equal to bc_tag
//                         (bc_valid must already be qualified by the caller)
module reg_status_table
   import cpu_types::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic [4:0] rd_addr1,
   input  logic [4:0] rd_addr2,
   output RS_tag_type rd_tag1,
   output RS_tag_type rd_tag2,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  RS_tag_type wr_tag,
   input  logic       bc_valid,
   input  RS_tag_type bc_tag
);

   // x0 has no storage: it is hard-wired to TAG_NONE.
   RS_tag_type map_r [1:31];

   // Read ports with broadcast bypass.
   always_comb begin
      rd_tag1 = TAG_NONE;
      rd_tag2 = TAG_NONE;
      if (rd_addr1 == 5'd0) begin
         rd_tag1 = TAG_NONE;
      end else if (bc_valid && (map_r[rd_addr1] == bc_tag)) begin
         rd_tag1 = TAG_NONE;
      end else begin
         rd_tag1 = map_r[rd_addr1];
      end
      if (rd_addr2 == 5'd0) begin
         rd_tag2 = TAG_NONE;
      end else if (bc_valid && (map_r[rd_addr2] == bc_tag)) begin
         rd_tag2 = TAG_NONE;
      end else begin
         rd_tag2 = map_r[rd_addr2];
      end
   end

   // Map update: reset/clear, then write (priority) or broadcast clear per entry.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         for (int i = 1; i < 32; i++) begin
            map_r[i] <= TAG_NONE;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (wr_en && (wr_addr == 5'(i))) begin
               map_r[i] <= wr_tag;
            end else if (bc_valid && (map_r[i] == bc_tag)) begin
               map_r[i] <= TAG_NONE;
            end else begin
               map_r[i] <= map_r[i];
            end
         end
      end
   end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order task FIFO that dispatches its head to the lowest free
// reservation station and reports the producer tags of both source operands.
//   CLK, RST_N                 : clock, synchronous active-low reset
//   ENQ_VALID/ENQ_TASK/ENQ_READY : enqueue handshake
//   RS_BUSY                    : external busy flag per RS (bit i-1 = RS i)
//   CDB_VALID/CDB_TAG          : completion broadcast, frees an RS and its map entries
//   FLUSH                      : drop queued tasks, map table and RS claims
//   DISPATCH_VALID/DISPATCH_TASK/DEST_RES : head dispatch, combinational
//   T1/T2                      : producer tags of rs1/rs2 (TAG_NONE = ready)
module issue_queue
   import cpu_types::*;
#(
   parameter int DEPTH  = 4,
   parameter int NUM_RS = DEFAULT_NUM_RS
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              ENQ_VALID,
   input  task_t             ENQ_TASK,
   output logic              ENQ_READY,
   input  logic [NUM_RS-1:0] RS_BUSY,
   input  logic              CDB_VALID,
   input  RS_tag_type        CDB_TAG,
   input  logic              FLUSH,
   output logic              DISPATCH_VALID,
   output task_t             DISPATCH_TASK,
   output RS_tag_type        DEST_RES,
   output RS_tag_type        T1,
   output RS_tag_type        T2
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);

   task_t             mem_r [DEPTH];
   logic [PW-1:0]     rd_ptr_r;
   logic [PW-1:0]     wr_ptr_r;
   logic [CW-1:0]     count_r;
   logic [NUM_RS-1:0] alloc_r;

   logic [MAX_RS-1:0] free_s;
   RS_tag_type        dest_s;
   logic              cdb_hit_s;
   logic              enq_fire_s;
   logic              deq_fire_s;
   logic [CW-1:0]     count_next_s;
   logic [NUM_RS-1:0] alloc_next_s;

   // An RS is free when neither the outside world nor our own claim holds it.
   always_comb begin
      free_s = {MAX_RS{1'b0}};
      for (int i = 0; i < NUM_RS; i++) begin
         free_s[i] = !RS_BUSY[i] && !alloc_r[i];
      end
   end

   assign dest_s    = lowest_free(free_s);
   assign cdb_hit_s = CDB_VALID && tag_valid(CDB_TAG, NUM_RS);

   // Space freed by a same-cycle dispatch is not offered to that cycle's enqueue.
   assign ENQ_READY      = RST_N && (count_r != FULL_COUNT);
   assign DISPATCH_VALID = RST_N && !FLUSH && (count_r != {CW{1'b0}}) && (dest_s != TAG_NONE);
   assign DISPATCH_TASK  = mem_r[rd_ptr_r];
   assign DEST_RES       = dest_s;

   assign enq_fire_s = ENQ_VALID && ENQ_READY && !FLUSH;
   assign deq_fire_s = DISPATCH_VALID;

   // Occupancy: simultaneous enqueue and dequeue leave it unchanged.
   always_comb begin
      count_next_s = count_r;
      case ({enq_fire_s, deq_fire_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase
   end

   // Claim vector: broadcast releases first, then the dispatch claim is applied.
   always_comb begin
      alloc_next_s = alloc_r;
      for (int i = 0; i < NUM_RS; i++) begin
         if (cdb_hit_s && (CDB_TAG == RS_tag_type'(i + 1))) begin
            alloc_next_s[i] = 1'b0;
         end else begin
            alloc_next_s[i] = alloc_r[i];
         end
         if (deq_fire_s && (dest_s == RS_tag_type'(i + 1))) begin
            alloc_next_s[i] = 1'b1;
         end else begin
            alloc_next_s[i] = alloc_next_s[i];
         end
      end
   end

   // Queue control state: reset and flush both empty the queue and drop claims.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         alloc_r  <= {NUM_RS{1'b0}};
      end else if (FLUSH) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         alloc_r  <= {NUM_RS{1'b0}};
      end else begin
         rd_ptr_r <= deq_fire_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
         wr_ptr_r <= enq_fire_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
         count_r  <= count_next_s;
         alloc_r  <= alloc_next_s;
      end
   end

   // Entry storage; contents are only meaningful below the occupancy count.
   always_ff @(posedge CLK) begin
      if (enq_fire_s) begin
         mem_r[wr_ptr_r] <= ENQ_TASK;
      end
   end

   // Operand tags come from the map state before this cycle's dispatch write,
   // so a task with rs == rd sees the previous producer.
   reg_status_table u_map (
      .clk      (CLK),
      .rst_n    (RST_N),
      .clear    (FLUSH),
      .rd_addr1 (DISPATCH_TASK.rs1),
      .rd_addr2 (DISPATCH_TASK.rs2),
      .rd_tag1  (T1),
      .rd_tag2  (T2),
      .wr_en    (deq_fire_s && (DISPATCH_TASK.rd != 5'd0)),
      .wr_addr  (DISPATCH_TASK.rd),
      .wr_tag   (dest_s),
      .bc_valid (cdb_hit_s),
      .bc_tag   (CDB_TAG)
   );

endmodule
